// File: rtl/btn_debounce_strobe_pkg.sv
// Shared definitions for the push-button conditioner: FSM state encodings,
// default parameter values and a small constant helper.
package btn_debounce_strobe_pkg;

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    PRESSED   = 2'd1,
    REPEATING = 2'd2
  } btn_state_e;

  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_PRESCALE     = 1000;
  localparam int DEF_STABLE_TICKS = 8;
  localparam int DEF_REPEAT_DELAY = 64;
  localparam int DEF_REPEAT_RATE  = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: tick is high for one clk cycle out of every PRESCALE.
// Kept generic so later display stages can share it.
module tick_prescaler
  import btn_debounce_strobe_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int            CNT_W    = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/btn_debounce_strobe.sv
// Push-button conditioner feeding the count stage: synchronise, debounce on a
// prescaled sample tick, and emit registered press/release/increment strobes.
module btn_debounce_strobe
  import btn_debounce_strobe_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int PRESCALE     = DEF_PRESCALE,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic inc_strobe
);

  localparam int STAB_W = $clog2(STABLE_TICKS + 1);
  localparam int RPT_W  = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);

  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_TICKS - 1);
  localparam logic [RPT_W-1:0]  RPT_DELAY = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0]  RPT_RATE  = RPT_W'(REPEAT_RATE);

  logic                   sample_tick;
  logic [SYNC_STAGES-1:0] sync_p;
  logic                   btn_sync;
  logic [STAB_W-1:0]      stab_cnt;
  logic                   differs;
  logic                   flip;
  logic                   rise;
  logic                   fall;

  btn_state_e             state_q;
  btn_state_e             state_d;
  logic [RPT_W-1:0]       rpt_cnt;
  logic [RPT_W-1:0]       rpt_d;
  logic [RPT_W-1:0]       rpt_sat;
  logic [RPT_W-1:0]       rpt_inc;
  logic                   inc_d;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (sample_tick)
  );

  // Stage: input synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p <= '0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], btn_raw};
    end
  end

  assign btn_sync = sync_p[SYNC_STAGES-1];

  // Stage: debounce; the level only moves after STABLE_TICKS differing samples in a row
  assign differs = sample_tick && (btn_sync != btn_level);
  assign flip    = differs && (stab_cnt == STAB_LAST);
  assign rise    = flip && !btn_level;
  assign fall    = flip &&  btn_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_cnt  <= '0;
      btn_level <= 1'b0;
    end else if (sample_tick) begin
      if (!differs) begin
        stab_cnt <= '0;
      end else if (flip) begin
        stab_cnt  <= '0;
        btn_level <= ~btn_level;
      end else begin
        stab_cnt <= stab_cnt + 1'b1;
      end
    end
  end

  // Stage: press / auto-repeat FSM
  assign rpt_inc = rpt_cnt + 1'b1;
  assign rpt_sat = (rpt_cnt >= RPT_DELAY) ? RPT_DELAY : rpt_inc;

  always_comb begin
    state_d = state_q;
    rpt_d   = rpt_cnt;
    inc_d   = 1'b0;
    if (fall) begin
      // a release beats any repeat expiry landing on the same tick
      state_d = RELEASED;
      rpt_d   = '0;
    end else begin
      unique case (state_q)
        RELEASED: begin
          if (rise) begin
            state_d = PRESSED;
            rpt_d   = '0;
            inc_d   = 1'b1;
          end
        end
        PRESSED: begin
          if (sample_tick) begin
            rpt_d = rpt_sat;
            if ((rpt_sat == RPT_DELAY) && repeat_en) begin
              state_d = REPEATING;
              rpt_d   = '0;
              inc_d   = 1'b1;
            end
          end
        end
        REPEATING: begin
          if (!repeat_en) begin
            state_d = PRESSED;
            rpt_d   = '0;
          end else if (sample_tick) begin
            if (rpt_inc == RPT_RATE) begin
              rpt_d = '0;
              inc_d = 1'b1;
            end else begin
              rpt_d = rpt_inc;
            end
          end
        end
        default: begin
          state_d = RELEASED;
          rpt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RELEASED;
      rpt_cnt       <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      inc_strobe    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rpt_cnt       <= rpt_d;
      press_pulse   <= rise;
      release_pulse <= fall;
      inc_strobe    <= inc_d;
    end
  end

endmodule

// File: tb/tb_btn_debounce_strobe.sv
// Scoreboard bench for btn_debounce_strobe: a cycle-level reference model pushes the
// expected outputs for every driven cycle; the monitor pops and compares one cycle later.
module tb_btn_debounce_strobe;

  localparam int SY = 2;
  localparam int P  = 4;
  localparam int ST = 3;
  localparam int RD = 5;
  localparam int RR = 2;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic btn_raw   = 1'b1;
  logic repeat_en = 1'b0;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic inc_strobe;

  always #5 clk = ~clk;

  btn_debounce_strobe #(
    .SYNC_STAGES  (SY),
    .PRESCALE     (P),
    .STABLE_TICKS (ST),
    .REPEAT_DELAY (RD),
    .REPEAT_RATE  (RR)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_raw       (btn_raw),
    .repeat_en     (repeat_en),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .inc_strobe    (inc_strobe)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model state
  int         m_n;
  bit         m_hist [0:4095];
  bit         m_lvl;
  int         m_stab;
  int         m_st;
  int         m_rpt;
  logic [3:0] exp_q [$];

  int gcyc = 0;
  int press_cnt;
  int rel_cnt;
  int rise_t;
  int inc_t [$];

  task automatic model_reset();
    m_n    = 0;
    m_lvl  = 1'b0;
    m_stab = 0;
    m_st   = 0;
    m_rpt  = 0;
    exp_q.delete();
  endtask

  task automatic model_edge(input bit raw, input bit ren);
    bit s, tk, rise, fall, inc;
    m_n++;
    m_hist[m_n] = raw;
    s    = (m_n - SY >= 1) ? m_hist[m_n - SY] : 1'b0;
    tk   = (m_n % P == 0);
    rise = 1'b0;
    fall = 1'b0;
    inc  = 1'b0;
    if (tk) begin
      if (s != m_lvl) begin
        m_stab++;
        if (m_stab == ST) begin
          m_stab = 0;
          m_lvl  = s;
          rise   = s;
          fall   = !s;
        end
      end else begin
        m_stab = 0;
      end
    end
    if (fall) begin
      m_st  = 0;
      m_rpt = 0;
    end else if (m_st == 0) begin
      if (rise) begin
        m_st  = 1;
        m_rpt = 0;
        inc   = 1'b1;
      end
    end else if (m_st == 1) begin
      if (tk) begin
        if (m_rpt < RD) m_rpt++;
        if (m_rpt == RD && ren) begin
          m_st  = 2;
          m_rpt = 0;
          inc   = 1'b1;
        end
      end
    end else begin
      if (!ren) begin
        m_st  = 1;
        m_rpt = 0;
      end else if (tk) begin
        m_rpt++;
        if (m_rpt == RR) begin
          m_rpt = 0;
          inc   = 1'b1;
        end
      end
    end
    exp_q.push_back({m_lvl, rise, fall, inc});
  endtask

  task automatic clear_counts();
    press_cnt = 0;
    rel_cnt   = 0;
    rise_t    = -1;
    inc_t.delete();
  endtask

  task automatic observe();
    logic [3:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_val($sformatf("outs@%0d", gcyc), {btn_level, press_pulse, release_pulse, inc_strobe}, e);
    end
    if (press_pulse === 1'b1) begin
      press_cnt++;
      rise_t = gcyc;
    end
    if (release_pulse === 1'b1) rel_cnt++;
    if (inc_strobe === 1'b1) inc_t.push_back(gcyc);
  endtask

  task automatic drive(input bit raw, input bit ren);
    btn_raw   = raw;
    repeat_en = ren;
    gcyc++;
    model_edge(raw, ren);
  endtask

  task automatic step(input bit raw, input bit ren);
    @(negedge clk);
    observe();
    drive(raw, ren);
  endtask

  task automatic hold(input bit raw, input bit ren, input int n);
    for (int i = 0; i < n; i++) step(raw, ren);
  endtask

  task automatic do_reset(input bit raw, input bit ren);
    @(posedge clk);
    #1;
    observe();
    #1 rst_n = 1'b0;
    #1 chk_val("async_rst", {btn_level, press_pulse, release_pulse, inc_strobe}, 0);
    repeat (3) @(negedge clk);
    chk_val("held_rst", {btn_level, press_pulse, release_pulse, inc_strobe}, 0);
    rst_n = 1'b1;
    model_reset();
    drive(raw, ren);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t reached, limit 100000", $time);
    $fatal(1);
  end

  initial begin
    int g0;
    int d;
    int first;

    // reset with the button held high
    model_reset();
    clear_counts();
    repeat (2) @(negedge clk);
    chk_val("rst_outs", {btn_level, press_pulse, release_pulse, inc_strobe}, 0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0);
    hold(1'b0, 1'b0, 10);

    // clean press, no repeat
    clear_counts();
    g0 = gcyc + 1;
    hold(1'b1, 1'b0, 40);
    hold(1'b0, 1'b0, 20);
    chk_val("press_cnt", press_cnt, 1);
    chk_val("inc_cnt", inc_t.size(), 1);
    chk_val("rel_cnt", rel_cnt, 1);
    chk_val("rise_latency_ok", (rise_t - g0 >= 10) && (rise_t - g0 <= 14), 1);
    if (inc_t.size() > 0) chk_val("inc_with_press", inc_t[0], rise_t);

    // bounce shorter than the stability window
    clear_counts();
    for (int k = 0; k < 6; k++) hold(k % 2 == 0, 1'b0, 5);
    hold(1'b0, 1'b0, 20);
    chk_val("bounce_press", press_cnt, 0);
    chk_val("bounce_rel", rel_cnt, 0);
    chk_val("bounce_inc", inc_t.size(), 0);
    chk_val("bounce_level", btn_level, 0);

    // auto-repeat
    clear_counts();
    hold(1'b1, 1'b1, 100);
    hold(1'b0, 1'b1, 20);
    chk_val("rpt_press", press_cnt, 1);
    chk_val("rpt_rel", rel_cnt, 1);
    chk_val("rpt_enough", inc_t.size() >= 4, 1);
    if (inc_t.size() >= 4) begin
      chk_val("rpt_first_gap", inc_t[1] - inc_t[0], 20);
      chk_val("rpt_gap2", inc_t[2] - inc_t[1], 8);
      chk_val("rpt_gap3", inc_t[3] - inc_t[2], 8);
    end

    // repeat_en dropped while repeating, then re-raised
    clear_counts();
    hold(1'b1, 1'b1, 50);
    d = gcyc + 1;
    hold(1'b1, 1'b0, 6);
    hold(1'b1, 1'b1, 40);
    first = -1;
    foreach (inc_t[i]) if (inc_t[i] >= d && first < 0) first = inc_t[i];
    chk_val("resume_gap_ok", (first - d >= 17) && (first - d <= 20), 1);
    hold(1'b0, 1'b1, 20);
    chk_val("resume_rel", rel_cnt, 1);

    // reset while repeating, button still held afterwards
    clear_counts();
    hold(1'b1, 1'b1, 45);
    chk_val("pre_rst_level", btn_level, 1);
    do_reset(1'b1, 1'b0);
    clear_counts();
    hold(1'b1, 1'b0, 30);
    hold(1'b0, 1'b0, 20);
    @(negedge clk);
    observe();
    chk_val("post_rst_press", press_cnt, 1);
    chk_val("post_rst_inc", inc_t.size(), 1);
    chk_val("post_rst_rel", rel_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
